tia_playfield_serializer: RTL

// - Single-clock, parametrised playfield generator; successor to the biphase-clocked TIA playfield registers.
// - Owns the horizontal position counter, byte-lane playfield storage and control register.
// - Serialises one playfield bit per CLKS_PER_BIT colour clocks across both halves of the visible line.
// - Drives pf and score-half select into the priority/colour mixer.

---
 rtl/tia_playfield_serializer_pkg.sv | 34 +++
 rtl/tia_playfield_serializer_bit_select.sv | 34 +++
 rtl/tia_playfield_serializer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/tia_playfield_serializer_pkg.sv
// Shared constants and helpers for the playfield serializer slice.
// Build option: TIA_PF_LEGACY_ORDER_EN selects the original TIA PF0/PF1/PF2
// bit ordering (uses legacy_bit_index below).
package tia_pf_pkg;

    // Bit positions inside the CTRL register; bits [7:2] are ignored.
    localparam int unsigned CTRL_REFLECT_BIT = 0;
    localparam int unsigned CTRL_SCORE_BIT   = 1;

    // Number of byte lanes needed to hold pf_bits playfield bits.
    function automatic int unsigned nlanes(input int unsigned pf_bits);
        return (pf_bits + 7) / 8;
    endfunction

    // Original TIA register ordering for a 20-bit playfield.
    // Returns the playfield bit written by wr_data[data_bit] of register
    // 'lane' (0 = PF0, 1 = PF1, 2 = PF2), or -1 when that data bit is dropped.
    //   PF0: wr_data[4..7] -> bits 0..3 (low nibble unused)
    //   PF1: wr_data[7..0] -> bits 4..11 (reversed)
    //   PF2: wr_data[0..7] -> bits 12..19
    function automatic int legacy_bit_index(input int unsigned lane,
                                            input int unsigned data_bit);
        int idx;
        idx = -1;
        case (lane)
            0:       if (data_bit >= 4) idx = int'(data_bit) - 4;
            1:       idx = 4 + (7 - int'(data_bit));
            2:       idx = 12 + int'(data_bit);
            default: idx = -1;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/tia_playfield_serializer_bit_select.sv
// Playfield bit selector: maps the bit counter of the visible line onto a
// stored playfield bit, mirroring the right half when reflect is set.
module tia_pf_bit_select
    import tia_pf_pkg::*;
#(
    parameter int unsigned PF_BITS = 20,
    parameter int unsigned BW      = $clog2(2 * PF_BITS)
) (
    input  logic [PF_BITS-1:0] bits,
    input  logic [BW-1:0]      b,
    input  logic               reflect,
    output logic               bit_val
);

    logic [BW-1:0] idx;

    // Translate line bit counter to storage index, then mux the stored bit.
    always_comb begin
        idx     = b;
        bit_val = 1'b0;
        if (b < BW'(PF_BITS)) begin
            idx = b;
        end else if (reflect) begin
            // PF_BITS-1-r with r = b-PF_BITS folds to 2*PF_BITS-1-b.
            idx = BW'(2 * PF_BITS - 1) - b;
        end else begin
            idx = b - BW'(PF_BITS);
        end
        for (int unsigned i = 0; i < PF_BITS; i++) begin
            if (idx == BW'(i)) bit_val = bits[i];
        end
    end

endmodule

// File: rtl/tia_playfield_serializer.sv
// Single-clock playfield serializer: horizontal counter, playfield byte
// lanes, CTRL register (REFLECT/SCORE) and the bit-boundary latch that
// drives pf / pf_right into the colour mixer.
// Build option: TIA_PF_LEGACY_ORDER_EN maps addresses 0/1/2 to the original
// TIA PF0/PF1/PF2 ordering (PF_BITS must be 20); otherwise lanes are linear.
module tia_playfield_serializer
    import tia_pf_pkg::*;
#(
    parameter  int unsigned PF_BITS      = 20,
    parameter  int unsigned CLKS_PER_BIT = 4,
    parameter  int unsigned HBLANK_CLKS  = 68,
    parameter  int unsigned LINE_CLKS    = 228,
    localparam int unsigned NLANES       = nlanes(PF_BITS),
    localparam int unsigned AW           = $clog2(NLANES + 1),
    localparam int unsigned HW           = $clog2(LINE_CLKS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic [HW-1:0] hpos,
    output logic          hblank,
    output logic          line_start,
    output logic          pf,
    output logic          pf_right
);

    localparam int unsigned BW  = $clog2(2 * PF_BITS);
    localparam int unsigned PHW = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned PIW = $clog2(PF_BITS);

    if (LINE_CLKS != HBLANK_CLKS + 2 * PF_BITS * CLKS_PER_BIT) begin : g_bad_line
        $error("LINE_CLKS must equal HBLANK_CLKS + 2*PF_BITS*CLKS_PER_BIT");
    end

`ifdef TIA_PF_LEGACY_ORDER_EN
    if (PF_BITS != 20) begin : g_bad_legacy
        $error("legacy TIA register ordering requires PF_BITS == 20");
    end
`endif

    // Registered, mutually aligned outputs.
    logic [HW-1:0]      hpos_q;
    logic               hblank_q;
    logic               line_start_q;
    logic               pf_q;
    logic               pf_right_q;

    // Position inside the visible area: phase within a bit, bit number.
    logic [PHW-1:0]     phase_q, phase_n;
    logic [BW-1:0]      bit_q, bit_n;
    logic [HW-1:0]      hpos_n;
    logic               active_n;
    logic               boundary_n;
    logic               right_n;

    // Register file.
    logic [PF_BITS-1:0] bits_q;
    logic [1:0]         ctrl_q;
    logic [PF_BITS-1:0] wmask;
    logic [PF_BITS-1:0] wdata;
    logic               ctrl_we;
    logic [31:0]        addr_ext;
    logic               sel_bit;

`ifdef TIA_PF_LEGACY_ORDER_EN
    int                 legacy_idx;
`endif

    assign addr_ext = 32'(wr_addr);

    // Next horizontal position and bit-boundary tracking for the next cycle.
    always_comb begin
        hpos_n     = (hpos_q == HW'(LINE_CLKS - 1)) ? '0 : hpos_q + 1'b1;
        active_n   = (hpos_n >= HW'(HBLANK_CLKS));
        phase_n    = phase_q;
        bit_n      = bit_q;
        boundary_n = 1'b0;
        if (hpos_n == HW'(HBLANK_CLKS)) begin
            phase_n    = '0;
            bit_n      = '0;
            boundary_n = 1'b1;
        end else if (!hblank_q) begin
            if (phase_q == PHW'(CLKS_PER_BIT - 1)) begin
                phase_n    = '0;
                bit_n      = bit_q + 1'b1;
                boundary_n = 1'b1;
            end else begin
                phase_n    = phase_q + 1'b1;
            end
        end
        right_n = (bit_n >= BW'(PF_BITS));
    end

    // Decode a register write into a per-bit playfield mask plus CTRL strobe.
    always_comb begin
        wmask   = '0;
        wdata   = '0;
        ctrl_we = wr_en && (addr_ext == NLANES);
`ifdef TIA_PF_LEGACY_ORDER_EN
        legacy_idx = -1;
        for (int unsigned k = 0; k < 3; k++) begin
            for (int unsigned i = 0; i < 8; i++) begin
                legacy_idx = legacy_bit_index(k, i);
                if (wr_en && (addr_ext == k) && (legacy_idx >= 0)) begin
                    wmask[PIW'(legacy_idx)] = 1'b1;
                    wdata[PIW'(legacy_idx)] = wr_data[i];
                end
            end
        end
`else
        for (int unsigned k = 0; k < NLANES; k++) begin
            for (int unsigned i = 0; i < 8; i++) begin
                // Bits past PF_BITS in the top lane are simply not stored.
                if (wr_en && (addr_ext == k) && (8 * k + i < PF_BITS)) begin
                    wmask[PIW'(8 * k + i)] = 1'b1;
                    wdata[PIW'(8 * k + i)] = wr_data[i];
                end
            end
        end
`endif
    end

    tia_pf_bit_select #(
        .PF_BITS (PF_BITS),
        .BW      (BW)
    ) u_bit_select (
        .bits    (bits_q),
        .b       (bit_n),
        .reflect (ctrl_q[CTRL_REFLECT_BIT]),
        .bit_val (sel_bit)
    );

    // Counter, registers and the boundary latch; the latch sees pre-write
    // register values because writes land on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            hpos_q       <= '0;
            hblank_q     <= 1'b1;
            line_start_q <= 1'b1;
            pf_q         <= 1'b0;
            pf_right_q   <= 1'b0;
            phase_q      <= '0;
            bit_q        <= '0;
            bits_q       <= '0;
            ctrl_q       <= '0;
        end else begin
            hpos_q       <= hpos_n;
            hblank_q     <= !active_n;
            line_start_q <= (hpos_n == '0);
            phase_q      <= phase_n;
            bit_q        <= bit_n;
            bits_q       <= (bits_q & ~wmask) | wdata;
            if (ctrl_we) begin
                ctrl_q[CTRL_REFLECT_BIT] <= wr_data[CTRL_REFLECT_BIT];
                ctrl_q[CTRL_SCORE_BIT]   <= wr_data[CTRL_SCORE_BIT];
            end
            if (!active_n) begin
                pf_q       <= 1'b0;
                pf_right_q <= 1'b0;
            end else if (boundary_n) begin
                pf_q       <= sel_bit;
                pf_right_q <= right_n && ctrl_q[CTRL_SCORE_BIT];
            end
        end
    end

    assign hpos       = hpos_q;
    assign hblank     = hblank_q;
    assign line_start = line_start_q;
    assign pf         = pf_q;
    assign pf_right   = pf_right_q;

endmodule
